// File: rtl/mips_exec_control.sv
// mips_exec_control: single-cycle MIPS main decoder, ALU-control decoder,
// 32-bit ALU with branch evaluation and optional HI/LO registers.
// Define MULDIV_EN to build the multiply/divide unit and the HI/LO registers;
// without it MFHI/MTHI/MFLO/MTLO/MULT/MULTU/DIV/DIVU decode as unrecognised.
module mips_exec_control (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        active,
  input  logic [31:0] instr_readdata,
  input  logic [31:0] reg_data_a,
  input  logic [31:0] alu_input,
  output logic [1:0]  pc_sel,
  output logic        branch_is_true,
  output logic        data_write,
  output logic        data_read,
  output logic [3:0]  byte_enable,
  output logic        reg_write_enable,
  output logic [1:0]  reg_addr_sel,
  output logic [1:0]  reg_data_sel,
  output logic        alu_sel,
  output logic        signextend_sel,
  output logic [31:0] alu_result
);

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [4:0] RT_BLTZ   = 5'd0;
  localparam logic [4:0] RT_BGEZ   = 5'd1;
  localparam logic [4:0] RT_BLTZAL = 5'd16;
  localparam logic [4:0] RT_BGEZAL = 5'd17;

  localparam logic [4:0] ALU_ZERO = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_AND  = 5'd3;
  localparam logic [4:0] ALU_OR   = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SLT  = 5'd6;
  localparam logic [4:0] ALU_SLTU = 5'd7;
  localparam logic [4:0] ALU_SLL  = 5'd8;
  localparam logic [4:0] ALU_SRL  = 5'd9;
  localparam logic [4:0] ALU_SRA  = 5'd10;
  localparam logic [4:0] ALU_SLLV = 5'd11;
  localparam logic [4:0] ALU_SRLV = 5'd12;
  localparam logic [4:0] ALU_SRAV = 5'd13;
  localparam logic [4:0] ALU_LUI  = 5'd14;

  localparam logic [1:0] MEM_NONE = 2'd0;
  localparam logic [1:0] MEM_WORD = 2'd1;
  localparam logic [1:0] MEM_HALF = 2'd2;
  localparam logic [1:0] MEM_BYTE = 2'd3;

`ifdef MULDIV_EN
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  localparam logic [4:0] ALU_MFHI = 5'd15;
  localparam logic [4:0] ALU_MFLO = 5'd16;

  localparam logic [2:0] HILO_NONE  = 3'd0;
  localparam logic [2:0] HILO_MTHI  = 3'd1;
  localparam logic [2:0] HILO_MTLO  = 3'd2;
  localparam logic [2:0] HILO_MULT  = 3'd3;
  localparam logic [2:0] HILO_MULTU = 3'd4;
  localparam logic [2:0] HILO_DIV   = 3'd5;
  localparam logic [2:0] HILO_DIVU  = 3'd6;
`endif

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [4:0]  w_rt;
  logic [4:0]  w_shamt;
  logic [15:0] w_imm;
  logic        w_aNeg;
  logic        w_aZero;
  logic        w_strobeEn;

  logic [1:0]  w_pcSel;
  logic        w_branch;
  logic        w_regWrite;
  logic        w_memRead;
  logic        w_memWrite;
  logic [1:0]  w_memSize;
  logic [1:0]  w_regAddrSel;
  logic [1:0]  w_regDataSel;
  logic        w_aluSel;
  logic        w_signExt;
  logic [4:0]  w_aluOp;
  logic [31:0] w_aluResult;
  logic [3:0]  w_byteEnable;
  logic        w_unused;

  assign w_opcode = instr_readdata[31:26];
  assign w_rt     = instr_readdata[20:16];
  assign w_shamt  = instr_readdata[10:6];
  assign w_funct  = instr_readdata[5:0];
  assign w_imm    = instr_readdata[15:0];
  assign w_aNeg   = reg_data_a[31];
  assign w_aZero  = (reg_data_a == 32'd0);

  // Every write strobe dies while the core is idle, stalled or held in reset.
  assign w_strobeEn = active & clk_enable & reset;

`ifdef MULDIV_EN
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [2:0]  w_hiloOp;
  logic [63:0] w_prodSigned;
  logic [63:0] w_prodUnsigned;
  logic        w_divByZero;
  logic [31:0] w_divisor;
  logic [31:0] w_quotSigned;
  logic [31:0] w_remSigned;
  logic [31:0] w_quotUnsigned;
  logic [31:0] w_remUnsigned;
  assign w_unused = ^instr_readdata[25:21];
`else
  assign w_unused = ^{clk, instr_readdata[25:21]};
`endif

  // Main and ALU-control decode: selects always follow the instruction,
  // unrecognised encodings fall through to the all-zero defaults.
  always_comb begin
    w_pcSel      = 2'd0;
    w_branch     = 1'b0;
    w_regWrite   = 1'b0;
    w_memRead    = 1'b0;
    w_memWrite   = 1'b0;
    w_memSize    = MEM_NONE;
    w_regAddrSel = 2'd0;
    w_regDataSel = 2'd0;
    w_aluSel     = 1'b0;
    w_signExt    = 1'b0;
    w_aluOp      = ALU_ZERO;
`ifdef MULDIV_EN
    w_hiloOp     = HILO_NONE;
`endif
    case (w_opcode)
      OP_RTYPE: begin
        w_regAddrSel = 2'd1;
        case (w_funct)
          FN_ADDU: begin w_regWrite = 1'b1; w_aluOp = ALU_ADD;  end
          FN_SUBU: begin w_regWrite = 1'b1; w_aluOp = ALU_SUB;  end
          FN_AND:  begin w_regWrite = 1'b1; w_aluOp = ALU_AND;  end
          FN_OR:   begin w_regWrite = 1'b1; w_aluOp = ALU_OR;   end
          FN_XOR:  begin w_regWrite = 1'b1; w_aluOp = ALU_XOR;  end
          FN_SLT:  begin w_regWrite = 1'b1; w_aluOp = ALU_SLT;  end
          FN_SLTU: begin w_regWrite = 1'b1; w_aluOp = ALU_SLTU; end
          FN_SLL:  begin w_regWrite = 1'b1; w_aluOp = ALU_SLL;  end
          FN_SRL:  begin w_regWrite = 1'b1; w_aluOp = ALU_SRL;  end
          FN_SRA:  begin w_regWrite = 1'b1; w_aluOp = ALU_SRA;  end
          FN_SLLV: begin w_regWrite = 1'b1; w_aluOp = ALU_SLLV; end
          FN_SRLV: begin w_regWrite = 1'b1; w_aluOp = ALU_SRLV; end
          FN_SRAV: begin w_regWrite = 1'b1; w_aluOp = ALU_SRAV; end
          FN_JR:   w_pcSel = 2'd3;
          FN_JALR: begin
            w_pcSel      = 2'd3;
            w_regWrite   = 1'b1;
            w_regDataSel = 2'd3;
          end
`ifdef MULDIV_EN
          FN_MFHI:  begin w_regWrite = 1'b1; w_aluOp = ALU_MFHI; end
          FN_MFLO:  begin w_regWrite = 1'b1; w_aluOp = ALU_MFLO; end
          FN_MTHI:  w_hiloOp = HILO_MTHI;
          FN_MTLO:  w_hiloOp = HILO_MTLO;
          FN_MULT:  w_hiloOp = HILO_MULT;
          FN_MULTU: w_hiloOp = HILO_MULTU;
          FN_DIV:   w_hiloOp = HILO_DIV;
          FN_DIVU:  w_hiloOp = HILO_DIVU;
`endif
          default: ;
        endcase
      end
      OP_REGIMM: begin
        case (w_rt)
          RT_BLTZ: begin w_pcSel = 2'd1; w_branch = w_aNeg;  end
          RT_BGEZ: begin w_pcSel = 2'd1; w_branch = ~w_aNeg; end
          RT_BLTZAL: begin
            w_pcSel      = 2'd1;
            w_branch     = w_aNeg;
            w_regWrite   = 1'b1;
            w_regAddrSel = 2'd2;
            w_regDataSel = 2'd3;
          end
          RT_BGEZAL: begin
            w_pcSel      = 2'd1;
            w_branch     = ~w_aNeg;
            w_regWrite   = 1'b1;
            w_regAddrSel = 2'd2;
            w_regDataSel = 2'd3;
          end
          default: ;
        endcase
      end
      OP_BEQ:  begin w_pcSel = 2'd1; w_branch = (reg_data_a == alu_input); end
      OP_BNE:  begin w_pcSel = 2'd1; w_branch = (reg_data_a != alu_input); end
      OP_BLEZ: begin w_pcSel = 2'd1; w_branch = w_aNeg | w_aZero;        end
      OP_BGTZ: begin w_pcSel = 2'd1; w_branch = ~w_aNeg & ~w_aZero;      end
      OP_J:    w_pcSel = 2'd2;
      OP_JAL: begin
        w_pcSel      = 2'd2;
        w_regWrite   = 1'b1;
        w_regAddrSel = 2'd2;
        w_regDataSel = 2'd3;
      end
      OP_ADDIU: begin w_regWrite = 1'b1; w_aluSel = 1'b1; w_signExt = 1'b1; w_aluOp = ALU_ADD;  end
      OP_SLTI:  begin w_regWrite = 1'b1; w_aluSel = 1'b1; w_signExt = 1'b1; w_aluOp = ALU_SLT;  end
      OP_SLTIU: begin w_regWrite = 1'b1; w_aluSel = 1'b1; w_signExt = 1'b1; w_aluOp = ALU_SLTU; end
      OP_ANDI:  begin w_regWrite = 1'b1; w_aluSel = 1'b1; w_aluOp = ALU_AND; end
      OP_ORI:   begin w_regWrite = 1'b1; w_aluSel = 1'b1; w_aluOp = ALU_OR;  end
      OP_XORI:  begin w_regWrite = 1'b1; w_aluSel = 1'b1; w_aluOp = ALU_XOR; end
      OP_LUI:   begin w_regWrite = 1'b1; w_aluSel = 1'b1; w_aluOp = ALU_LUI; end
      OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: begin
        w_regWrite = 1'b1;
        w_memRead  = 1'b1;
        w_aluSel   = 1'b1;
        w_aluOp    = ALU_ADD;
        w_signExt  = (w_opcode != OP_LBU) && (w_opcode != OP_LHU);
        if (w_opcode == OP_LW) begin
          w_memSize    = MEM_WORD;
          w_regDataSel = 2'd1;
        end else begin
          w_memSize    = ((w_opcode == OP_LH) || (w_opcode == OP_LHU)) ? MEM_HALF : MEM_BYTE;
          w_regDataSel = 2'd2;
        end
      end
      OP_SW, OP_SH, OP_SB: begin
        w_memWrite = 1'b1;
        w_aluSel   = 1'b1;
        w_signExt  = 1'b1;
        w_aluOp    = ALU_ADD;
        case (w_opcode)
          OP_SW:   w_memSize = MEM_WORD;
          OP_SH:   w_memSize = MEM_HALF;
          default: w_memSize = MEM_BYTE;
        endcase
      end
      default: ;
    endcase
  end

  // ALU datapath; all arithmetic wraps modulo 2^32.
  always_comb begin
    w_aluResult = 32'd0;
    case (w_aluOp)
      ALU_ADD:  w_aluResult = reg_data_a + alu_input;
      ALU_SUB:  w_aluResult = reg_data_a - alu_input;
      ALU_AND:  w_aluResult = reg_data_a & alu_input;
      ALU_OR:   w_aluResult = reg_data_a | alu_input;
      ALU_XOR:  w_aluResult = reg_data_a ^ alu_input;
      ALU_SLT:  w_aluResult = {31'd0, $signed(reg_data_a) < $signed(alu_input)};
      ALU_SLTU: w_aluResult = {31'd0, reg_data_a < alu_input};
      ALU_SLL:  w_aluResult = alu_input << w_shamt;
      ALU_SRL:  w_aluResult = alu_input >> w_shamt;
      ALU_SRA:  w_aluResult = $signed(alu_input) >>> w_shamt;
      ALU_SLLV: w_aluResult = alu_input << reg_data_a[4:0];
      ALU_SRLV: w_aluResult = alu_input >> reg_data_a[4:0];
      ALU_SRAV: w_aluResult = $signed(alu_input) >>> reg_data_a[4:0];
      ALU_LUI:  w_aluResult = {w_imm, 16'd0};
`ifdef MULDIV_EN
      ALU_MFHI: w_aluResult = r_hi;
      ALU_MFLO: w_aluResult = r_lo;
`endif
      default: ;
    endcase
  end

  // Byte lanes follow the low address bits; non-memory ops keep all lanes on.
  always_comb begin
    w_byteEnable = 4'b1111;
    case (w_memSize)
      MEM_HALF: w_byteEnable = w_aluResult[1] ? 4'b1100 : 4'b0011;
      MEM_BYTE: w_byteEnable = 4'b0001 << w_aluResult[1:0];
      default:  ;
    endcase
  end

`ifdef MULDIV_EN
  assign w_prodUnsigned = {32'd0, reg_data_a} * {32'd0, alu_input};
  assign w_prodSigned   = $signed({{32{reg_data_a[31]}}, reg_data_a}) *
                          $signed({{32{alu_input[31]}}, alu_input});
  assign w_divByZero    = (alu_input == 32'd0);
  assign w_divisor      = w_divByZero ? 32'd1 : alu_input;
  assign w_quotSigned   = $signed(reg_data_a) / $signed(w_divisor);
  assign w_remSigned    = $signed(reg_data_a) % $signed(w_divisor);
  assign w_quotUnsigned = reg_data_a / w_divisor;
  assign w_remUnsigned  = reg_data_a % w_divisor;

  // HI/LO update; reset wins over any write, a zero divisor leaves both alone.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_strobeEn) begin
      case (w_hiloOp)
        HILO_MTHI:  r_hi <= reg_data_a;
        HILO_MTLO:  r_lo <= reg_data_a;
        HILO_MULT: begin
          r_hi <= w_prodSigned[63:32];
          r_lo <= w_prodSigned[31:0];
        end
        HILO_MULTU: begin
          r_hi <= w_prodUnsigned[63:32];
          r_lo <= w_prodUnsigned[31:0];
        end
        HILO_DIV: if (!w_divByZero) begin
          r_hi <= w_remSigned;
          r_lo <= w_quotSigned;
        end
        HILO_DIVU: if (!w_divByZero) begin
          r_hi <= w_remUnsigned;
          r_lo <= w_quotUnsigned;
        end
        default: ;
      endcase
    end
  end
`endif

  assign pc_sel           = w_pcSel;
  assign branch_is_true   = w_branch;
  assign data_write       = w_memWrite & w_strobeEn;
  assign data_read        = w_memRead & w_strobeEn;
  assign reg_write_enable = w_regWrite & w_strobeEn;
  assign byte_enable      = w_byteEnable;
  assign reg_addr_sel     = w_regAddrSel;
  assign reg_data_sel     = w_regDataSel;
  assign alu_sel          = w_aluSel;
  assign signextend_sel   = w_signExt;
  assign alu_result       = w_aluResult;

endmodule

// File: tb/tb_mips_exec_control.sv
// Testbench for mips_exec_control: directed steps followed by random
// instructions, each checked against a mnemonic-level reference model.
module tb_mips_exec_control;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        active;
  logic [31:0] instr_readdata;
  logic [31:0] reg_data_a;
  logic [31:0] alu_input;
  logic [1:0]  pc_sel;
  logic        branch_is_true;
  logic        data_write;
  logic        data_read;
  logic [3:0]  byte_enable;
  logic        reg_write_enable;
  logic [1:0]  reg_addr_sel;
  logic [1:0]  reg_data_sel;
  logic        alu_sel;
  logic        signextend_sel;
  logic [31:0] alu_result;

  mips_exec_control dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .active(active),
    .instr_readdata(instr_readdata), .reg_data_a(reg_data_a), .alu_input(alu_input),
    .pc_sel(pc_sel), .branch_is_true(branch_is_true), .data_write(data_write),
    .data_read(data_read), .byte_enable(byte_enable), .reg_write_enable(reg_write_enable),
    .reg_addr_sel(reg_addr_sel), .reg_data_sel(reg_data_sel), .alu_sel(alu_sel),
    .signextend_sel(signextend_sel), .alu_result(alu_result)
  );

  // Free-running core clock.
  always #5 clk = ~clk;

`ifdef MULDIV_EN
  localparam bit HasMulDiv = 1'b1;
`else
  localparam bit HasMulDiv = 1'b0;
`endif

  typedef enum int {
    M_ADDU, M_SUBU, M_AND, M_OR, M_XOR, M_SLT, M_SLTU,
    M_SLL, M_SRL, M_SRA, M_SLLV, M_SRLV, M_SRAV, M_JR, M_JALR,
    M_MFHI, M_MTHI, M_MFLO, M_MTLO, M_MULT, M_MULTU, M_DIV, M_DIVU,
    M_ADDIU, M_SLTI, M_SLTIU, M_ANDI, M_ORI, M_XORI, M_LUI,
    M_LB, M_LH, M_LW, M_LBU, M_LHU, M_SB, M_SH, M_SW,
    M_BEQ, M_BNE, M_BLEZ, M_BGTZ, M_BLTZ, M_BGEZ, M_BLTZAL, M_BGEZAL,
    M_J, M_JAL, M_BADOP, M_BADFN, M_BADRT, M_COUNT
  } mnem_t;

  int testsRun = 0;
  int testsFailed = 0;
  int stepNo = 0;

  logic [31:0] modelHi = 32'd0;
  logic [31:0] modelLo = 32'd0;

  logic [1:0]  expPc;
  logic        expBranch, expDw, expDr, expRwe, expAsel, expSext;
  logic [3:0]  expBe;
  logic [1:0]  expRas, expRds;
  logic [31:0] expRes;
  bit          kRas, kRds, kAsel, kSext, kRes;
  bit          pendHi, pendLo;
  logic [31:0] pendHiVal, pendLoVal;

  function automatic logic [31:0] encode(input mnem_t m, input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [15:0] imm, input logic [25:0] tgt);
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rtF;
    op = 6'h00; fn = 6'h00; rtF = rt;
    case (m)
      M_ADDU: fn = 6'h21;  M_SUBU: fn = 6'h23;  M_AND: fn = 6'h24;  M_OR: fn = 6'h25;
      M_XOR:  fn = 6'h26;  M_SLT:  fn = 6'h2A;  M_SLTU: fn = 6'h2B; M_SLL: fn = 6'h00;
      M_SRL:  fn = 6'h02;  M_SRA:  fn = 6'h03;  M_SLLV: fn = 6'h04; M_SRLV: fn = 6'h06;
      M_SRAV: fn = 6'h07;  M_JR:   fn = 6'h08;  M_JALR: fn = 6'h09; M_MFHI: fn = 6'h10;
      M_MTHI: fn = 6'h11;  M_MFLO: fn = 6'h12;  M_MTLO: fn = 6'h13; M_MULT: fn = 6'h18;
      M_MULTU: fn = 6'h19; M_DIV:  fn = 6'h1A;  M_DIVU: fn = 6'h1B; M_BADFN: fn = 6'h01;
      M_ADDIU: op = 6'h09; M_SLTI: op = 6'h0A;  M_SLTIU: op = 6'h0B; M_ANDI: op = 6'h0C;
      M_ORI:  op = 6'h0D;  M_XORI: op = 6'h0E;  M_LUI:  op = 6'h0F; M_LB:   op = 6'h20;
      M_LH:   op = 6'h21;  M_LW:   op = 6'h23;  M_LBU:  op = 6'h24; M_LHU:  op = 6'h25;
      M_SB:   op = 6'h28;  M_SH:   op = 6'h29;  M_SW:   op = 6'h2B; M_BEQ:  op = 6'h04;
      M_BNE:  op = 6'h05;  M_BLEZ: op = 6'h06;  M_BGTZ: op = 6'h07; M_J:    op = 6'h02;
      M_JAL:  op = 6'h03;  M_BADOP: op = 6'h3F;
      M_BLTZ:   begin op = 6'h01; rtF = 5'd0;  end
      M_BGEZ:   begin op = 6'h01; rtF = 5'd1;  end
      M_BLTZAL: begin op = 6'h01; rtF = 5'd16; end
      M_BGEZAL: begin op = 6'h01; rtF = 5'd17; end
      M_BADRT:  begin op = 6'h01; rtF = 5'd2;  end
      default: ;
    endcase
    if (op == 6'h00) return {op, rs, rtF, rd, sh, fn};
    if (m == M_J || m == M_JAL) return {op, tgt};
    return {op, rs, rtF, imm};
  endfunction

  // Reference model helpers, phrased per instruction class.
  task automatic setRegAlu(input logic [31:0] res);
    kRas = 1; expRas = 2'd1; kAsel = 1; expAsel = 1'b0;
    kRds = 1; expRds = 2'd0; kRes = 1; expRes = res;
  endtask

  task automatic setImmAlu(input logic [31:0] res, input bit sxKnown, input logic sx);
    kRas = 1; expRas = 2'd0; kAsel = 1; expAsel = 1'b1;
    kRds = 1; expRds = 2'd0; kRes = 1; expRes = res;
    kSext = sxKnown; expSext = sx;
  endtask

  task automatic setMem(input logic [31:0] addr, input int size, input bit isLoad,
                        input logic [1:0] rds, input bit sxKnown, input logic sx,
                        output bit wantRd, output bit wantWr, output bit wantRw);
    kAsel = 1; expAsel = 1'b1; kRes = 1; expRes = addr;
    kSext = sxKnown; expSext = sx;
    case (size)
      4:       expBe = 4'b1111;
      2:       expBe = (addr[1:0] >= 2) ? 4'b1100 : 4'b0011;
      default: expBe = 4'(1 << addr[1:0]);
    endcase
    wantRd = isLoad; wantWr = !isLoad; wantRw = isLoad;
    if (isLoad) begin
      kRas = 1; expRas = 2'd0; kRds = 1; expRds = rds;
    end
  endtask

  task automatic setBranch(input bit cond, input bit link, output bit wantRw);
    expPc = 2'd1; expBranch = cond; kAsel = 1; expAsel = 1'b0;
    wantRw = link;
    if (link) begin
      kRas = 1; expRas = 2'd2; kRds = 1; expRds = 2'd3;
    end
  endtask

  // Computes expected outputs and pending HI/LO writes for one instruction.
  task automatic computeExpected(input mnem_t m, input logic [15:0] imm, input logic [4:0] sh,
                                 input logic [31:0] a, input logic [31:0] b);
    mnem_t mm;
    bit wantRw, wantRd, wantWr, gate, hw, lw;
    logic [31:0] hv, lv;
    longint sp;
    longint unsigned up;
    int sa, sb;
    int unsigned ua, ub;
    logic [31:0] sxImm;
    mm = m;
    if (!HasMulDiv && (m inside {M_MFHI, M_MTHI, M_MFLO, M_MTLO, M_MULT, M_MULTU, M_DIV, M_DIVU}))
      mm = M_BADFN;
    expPc = 2'd0; expBranch = 1'b0; expBe = 4'b1111; expRes = 32'd0;
    expRas = 2'd0; expRds = 2'd0; expAsel = 1'b0; expSext = 1'b0;
    kRas = 0; kRds = 0; kAsel = 0; kSext = 0; kRes = 0;
    wantRw = 0; wantRd = 0; wantWr = 0; hw = 0; lw = 0; hv = 32'd0; lv = 32'd0;
    sa = $signed(a); sb = $signed(b); ua = a; ub = b;
    sxImm = {{16{imm[15]}}, imm};
    case (mm)
      M_ADDU: begin setRegAlu(a + b); wantRw = 1; end
      M_SUBU: begin setRegAlu(a - b); wantRw = 1; end
      M_AND:  begin setRegAlu(a & b); wantRw = 1; end
      M_OR:   begin setRegAlu(a | b); wantRw = 1; end
      M_XOR:  begin setRegAlu(a ^ b); wantRw = 1; end
      M_SLT:  begin setRegAlu((sa < sb) ? 32'd1 : 32'd0); wantRw = 1; end
      M_SLTU: begin setRegAlu((ua < ub) ? 32'd1 : 32'd0); wantRw = 1; end
      M_SLL:  begin setRegAlu(b << sh); wantRw = 1; end
      M_SRL:  begin setRegAlu(b >> sh); wantRw = 1; end
      M_SRA:  begin setRegAlu(32'(sb >>> sh)); wantRw = 1; end
      M_SLLV: begin setRegAlu(b << a[4:0]); wantRw = 1; end
      M_SRLV: begin setRegAlu(b >> a[4:0]); wantRw = 1; end
      M_SRAV: begin setRegAlu(32'(sb >>> a[4:0])); wantRw = 1; end
      M_JR:   expPc = 2'd3;
      M_JALR: begin expPc = 2'd3; wantRw = 1; kRas = 1; expRas = 2'd1; kRds = 1; expRds = 2'd3; end
      M_MFHI: begin setRegAlu(modelHi); wantRw = 1; end
      M_MFLO: begin setRegAlu(modelLo); wantRw = 1; end
      M_MTHI: begin hw = 1; hv = a; end
      M_MTLO: begin lw = 1; lv = a; end
      M_MULT: begin
        kAsel = 1; sp = longint'(sa) * longint'(sb);
        hw = 1; lw = 1; hv = sp[63:32]; lv = sp[31:0];
      end
      M_MULTU: begin
        kAsel = 1; up = longint'(ua) * longint'(ub);
        hw = 1; lw = 1; hv = up[63:32]; lv = up[31:0];
      end
      M_DIV: begin
        kAsel = 1;
        if (b != 0) begin hw = 1; lw = 1; hv = sa % sb; lv = sa / sb; end
      end
      M_DIVU: begin
        kAsel = 1;
        if (b != 0) begin hw = 1; lw = 1; hv = ua % ub; lv = ua / ub; end
      end
      M_ADDIU: begin setImmAlu(a + b, 1, 1'b1); wantRw = 1; end
      M_SLTI:  begin setImmAlu((sa < sb) ? 32'd1 : 32'd0, 1, 1'b1); wantRw = 1; end
      M_SLTIU: begin setImmAlu((ua < ub) ? 32'd1 : 32'd0, 1, 1'b1); wantRw = 1; end
      M_ANDI:  begin setImmAlu(a & b, 1, 1'b0); wantRw = 1; end
      M_ORI:   begin setImmAlu(a | b, 1, 1'b0); wantRw = 1; end
      M_XORI:  begin setImmAlu(a ^ b, 1, 1'b0); wantRw = 1; end
      M_LUI:   begin setImmAlu({imm, 16'h0000}, 0, 1'b0); wantRw = 1; end
      M_LW:  setMem(a + b, 4, 1, 2'd1, 0, 1'b0, wantRd, wantWr, wantRw);
      M_LH:  setMem(a + b, 2, 1, 2'd2, 1, 1'b1, wantRd, wantWr, wantRw);
      M_LHU: setMem(a + b, 2, 1, 2'd2, 1, 1'b0, wantRd, wantWr, wantRw);
      M_LB:  setMem(a + b, 1, 1, 2'd2, 1, 1'b1, wantRd, wantWr, wantRw);
      M_LBU: setMem(a + b, 1, 1, 2'd2, 1, 1'b0, wantRd, wantWr, wantRw);
      M_SW:  setMem(a + b, 4, 0, 2'd0, 0, 1'b0, wantRd, wantWr, wantRw);
      M_SH:  setMem(a + b, 2, 0, 2'd0, 0, 1'b0, wantRd, wantWr, wantRw);
      M_SB:  setMem(a + b, 1, 0, 2'd0, 0, 1'b0, wantRd, wantWr, wantRw);
      M_BEQ:    setBranch(a == b, 0, wantRw);
      M_BNE:    setBranch(a != b, 0, wantRw);
      M_BLEZ:   setBranch(sa <= 0, 0, wantRw);
      M_BGTZ:   setBranch(sa > 0, 0, wantRw);
      M_BLTZ:   setBranch(sa < 0, 0, wantRw);
      M_BGEZ:   setBranch(sa >= 0, 0, wantRw);
      M_BLTZAL: setBranch(sa < 0, 1, wantRw);
      M_BGEZAL: setBranch(sa >= 0, 1, wantRw);
      M_J:   expPc = 2'd2;
      M_JAL: begin expPc = 2'd2; wantRw = 1; kRas = 1; expRas = 2'd2; kRds = 1; expRds = 2'd3; end
      default: kRes = 1;
    endcase
    gate = active && clk_enable && reset;
    expRwe = wantRw && gate;
    expDr  = wantRd && gate;
    expDw  = wantWr && gate;
    pendHi = hw && gate; pendHiVal = hv;
    pendLo = lw && gate; pendLoVal = lv;
    if (sxImm == 32'hFFFF_FFFF && imm == 16'h0) pendHi = 1'b0;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, ".pc_sel"}, 32'(pc_sel), 32'(expPc));
    checkVal({tag, ".branch"}, 32'(branch_is_true), 32'(expBranch));
    checkVal({tag, ".data_write"}, 32'(data_write), 32'(expDw));
    checkVal({tag, ".data_read"}, 32'(data_read), 32'(expDr));
    checkVal({tag, ".byte_enable"}, 32'(byte_enable), 32'(expBe));
    checkVal({tag, ".reg_we"}, 32'(reg_write_enable), 32'(expRwe));
    if (kRas)  checkVal({tag, ".reg_addr_sel"}, 32'(reg_addr_sel), 32'(expRas));
    if (kRds)  checkVal({tag, ".reg_data_sel"}, 32'(reg_data_sel), 32'(expRds));
    if (kAsel) checkVal({tag, ".alu_sel"}, 32'(alu_sel), 32'(expAsel));
    if (kSext) checkVal({tag, ".signext_sel"}, 32'(signextend_sel), 32'(expSext));
    if (kRes)  checkVal({tag, ".alu_result"}, alu_result, expRes);
  endtask

  // One instruction per cycle: drive after the falling edge, check, then
  // let the rising edge commit the model's HI/LO state.
  task automatic applyStimulus(input mnem_t m, input logic [4:0] rt, input logic [4:0] sh,
                               input logic [15:0] imm, input logic [31:0] a, input logic [31:0] b,
                               input logic act, input logic ce, input logic rst);
    @(negedge clk);
    stepNo++;
    instr_readdata = encode(m, 5'(stepNo), rt, 5'(stepNo + 3), sh, imm, 26'(stepNo * 7));
    reg_data_a = a; alu_input = b; active = act; clk_enable = ce; reset = rst;
    computeExpected(m, imm, sh, a, b);
    #1;
    checkOutput($sformatf("%s#%0d", m.name(), stepNo));
    @(posedge clk);
    if (!rst) begin
      modelHi = 32'd0; modelLo = 32'd0;
    end else begin
      if (pendHi) modelHi = pendHiVal;
      if (pendLo) modelLo = pendLoVal;
    end
  endtask

  function automatic bit usesImm(input mnem_t m);
    return m inside {M_ADDIU, M_SLTI, M_SLTIU, M_ANDI, M_ORI, M_XORI, M_LUI,
                     M_LB, M_LH, M_LW, M_LBU, M_LHU, M_SB, M_SH, M_SW};
  endfunction

  // Directed scenarios followed by a randomized instruction stream.
  initial begin
    mnem_t m;
    logic [15:0] imm;
    logic [31:0] a, b;
    logic [4:0] sh;
    logic act, ce, rst;

    applyStimulus(M_BADOP, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    applyStimulus(M_ADDU, 5'd0, 5'd0, 16'h0, 32'h1, 32'h2, 1'b1, 1'b1, 1'b0);
    applyStimulus(M_MFHI, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
    applyStimulus(M_ADDIU, 5'd2, 5'd0, 16'hFFFF, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1);
    applyStimulus(M_LH, 5'd3, 5'd0, 16'h0002, 32'h1000, 32'h2, 1'b1, 1'b1, 1'b1);
    applyStimulus(M_LH, 5'd3, 5'd0, 16'h0002, 32'h1000, 32'h2, 1'b0, 1'b1, 1'b1);
    applyStimulus(M_SB, 5'd3, 5'd0, 16'h0003, 32'h1000, 32'h3, 1'b1, 1'b1, 1'b1);
    applyStimulus(M_BGEZAL, 5'd0, 5'd0, 16'h0010, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
    applyStimulus(M_BGEZAL, 5'd0, 5'd0, 16'h0010, 32'h8000_0000, 32'h0, 1'b1, 1'b1, 1'b1);
    applyStimulus(M_SRA, 5'd4, 5'd4, 16'h0, 32'h0, 32'h8000_0000, 1'b1, 1'b1, 1'b1);
    applyStimulus(M_SLTU, 5'd4, 5'd0, 16'h0, 32'h1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1);
    applyStimulus(M_SLT, 5'd4, 5'd0, 16'h0, 32'h1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1);
    applyStimulus(M_MULT, 5'd4, 5'd0, 16'h0, 32'hFFFF_FFFF, 32'h2, 1'b1, 1'b1, 1'b1);
    applyStimulus(M_MFHI, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
    applyStimulus(M_MFLO, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
    applyStimulus(M_DIVU, 5'd4, 5'd0, 16'h0, 32'h1234, 32'h0, 1'b1, 1'b1, 1'b1);
    applyStimulus(M_MFHI, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
    applyStimulus(M_MFLO, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
    applyStimulus(M_MTLO, 5'd0, 5'd0, 16'h0, 32'h1234_5678, 32'h0, 1'b1, 1'b1, 1'b1);
    applyStimulus(M_MFLO, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
    applyStimulus(M_MTLO, 5'd0, 5'd0, 16'h0, 32'h0000_DEAD, 32'h0, 1'b1, 1'b1, 1'b0);
    applyStimulus(M_MFLO, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
    applyStimulus(M_MTHI, 5'd0, 5'd0, 16'h0, 32'h5555_5555, 32'h0, 1'b1, 1'b1, 1'b1);
    applyStimulus(M_MTHI, 5'd0, 5'd0, 16'h0, 32'hAAAA_AAAA, 32'h0, 1'b1, 1'b0, 1'b1);
    applyStimulus(M_MFHI, 5'd0, 5'd0, 16'h0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1);
    applyStimulus(M_BADRT, 5'd2, 5'd0, 16'h0, 32'h8000_0000, 32'h0, 1'b1, 1'b1, 1'b1);
    applyStimulus(M_BADFN, 5'd2, 5'd0, 16'h0, 32'h5, 32'h6, 1'b1, 1'b1, 1'b1);

    for (int i = 0; i < 400; i++) begin
      m = mnem_t'($urandom_range(0, int'(M_COUNT) - 1));
      imm = 16'($urandom);
      sh = 5'($urandom);
      case ($urandom_range(0, 3))
        0:       a = 32'h0;
        1:       a = 32'h8000_0000 | 32'($urandom_range(0, 3));
        default: a = $urandom;
      endcase
      b = $urandom;
      if (usesImm(m))
        b = (m inside {M_ANDI, M_ORI, M_XORI, M_LUI}) ? {16'h0, imm} : {{16{imm[15]}}, imm};
      if ((m == M_BEQ || m == M_BNE) && $urandom_range(0, 1) == 1) b = a;
      if ((m == M_DIV || m == M_DIVU) && $urandom_range(0, 7) == 0) b = 32'h0;
      if (m == M_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) a = 32'h7FFF_FFFF;
      act = ($urandom_range(0, 9) != 0);
      ce  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 29) != 0);
      applyStimulus(m, 5'($urandom), sh, imm, a, b, act, ce, rst);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
